// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and resolve-update signal bundle for branch_predict_unit.
// When BPU_STATS_EN is defined the bundle also carries the statistics counters.
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic [XLEN-1:0] f_pred_pc;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [2:0]      r_bmc;
    logic            r_br;
    logic            r_jl;
    logic            r_jlr;
    logic            r_pl;
    logic            r_pred_taken;
    logic [XLEN-1:0] r_pred_pc;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

`ifdef BPU_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;

    modport master (
        output f_pc, r_valid, r_pc, r_imm, r_rs1, r_rs2, r_bmc,
               r_br, r_jl, r_jlr, r_pl, r_pred_taken, r_pred_pc,
        input  f_pred_taken, f_pred_pc, redirect, redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  f_pc, r_valid, r_pc, r_imm, r_rs1, r_rs2, r_bmc,
               r_br, r_jl, r_jlr, r_pl, r_pred_taken, r_pred_pc,
        output f_pred_taken, f_pred_pc, redirect, redirect_pc,
               stat_branches, stat_mispredicts
    );
`else
    modport master (
        output f_pc, r_valid, r_pc, r_imm, r_rs1, r_rs2, r_bmc,
               r_br, r_jl, r_jlr, r_pl, r_pred_taken, r_pred_pc,
        input  f_pred_taken, f_pred_pc, redirect, redirect_pc
    );

    modport slave (
        input  f_pc, r_valid, r_pc, r_imm, r_rs1, r_rs2, r_bmc,
               r_br, r_jl, r_jlr, r_pl, r_pred_taken, r_pred_pc,
        output f_pred_taken, f_pred_pc, redirect, redirect_pc
    );
`endif
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target predictor with 2-bit counters and same-cycle resolve redirect.
// Optional macro BPU_STATS_EN adds resolved-branch and mispredict counters.
module branch_predict_unit #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predict_unit_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    logic                r_vld [ENTRIES];
    logic [TAG_BITS-1:0] r_tag [ENTRIES];
    logic [XLEN-1:0]     r_tgt [ENTRIES];
    logic                r_jmp [ENTRIES];
    logic [1:0]          r_ctr [ENTRIES];

    logic [IDX_BITS-1:0] w_f_idx;
    logic [TAG_BITS-1:0] w_f_tag;
    logic                w_f_hit;
    logic                w_f_taken;

    assign w_f_idx = bus.f_pc[IDX_BITS+1:2];
    assign w_f_tag = bus.f_pc[TAG_HI:TAG_LO];

    // Lookup sees only fetch PC and current table; writes land after the edge.
    always_comb begin
        w_f_hit   = r_vld[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
        w_f_taken = rst_n && w_f_hit && (r_jmp[w_f_idx] || r_ctr[w_f_idx][1]);
        bus.f_pred_taken = w_f_taken;
        bus.f_pred_pc    = w_f_taken ? r_tgt[w_f_idx] : bus.f_pc + XLEN'(4);
    end

    logic                w_be;
    logic                w_cond_taken;
    logic                w_active;
    logic                w_act_taken;
    logic [XLEN-1:0]     w_jalr_sum;
    logic [XLEN-1:0]     w_act_target;
    logic [XLEN-1:0]     w_seq_pc;

    always_comb begin
        w_be = 1'b0;
        case (bus.r_bmc)
            3'b000:  w_be = (bus.r_rs1 == bus.r_rs2);
            3'b001:  w_be = (bus.r_rs1 != bus.r_rs2);
            3'b100:  w_be = ($signed(bus.r_rs1) <  $signed(bus.r_rs2));
            3'b101:  w_be = ($signed(bus.r_rs1) >= $signed(bus.r_rs2));
            3'b110:  w_be = (bus.r_rs1 <  bus.r_rs2);
            3'b111:  w_be = (bus.r_rs1 >= bus.r_rs2);
            default: w_be = 1'b0;
        endcase
    end

    assign w_cond_taken = bus.r_br & w_be;
    assign w_active     = rst_n & bus.r_valid & ~bus.r_pl;
    assign w_act_taken  = w_active & (w_cond_taken | bus.r_jl | bus.r_jlr);
    assign w_jalr_sum   = bus.r_rs1 + bus.r_imm;
    assign w_seq_pc     = bus.r_pc + XLEN'(4);

    // Register-indirect target only when neither a taken branch nor JAL claims the PC-relative one.
    assign w_act_target = (bus.r_jlr & ~bus.r_jl & ~w_cond_taken)
                        ? {w_jalr_sum[XLEN-1:1], 1'b0}
                        : bus.r_pc + bus.r_imm;

    assign bus.redirect    = w_active &
                             ((w_act_taken != bus.r_pred_taken) |
                              (w_act_taken & (w_act_target != bus.r_pred_pc)));
    assign bus.redirect_pc = w_act_taken ? w_act_target : w_seq_pc;

    logic [IDX_BITS-1:0] w_r_idx;
    logic [TAG_BITS-1:0] w_r_tag;
    logic                w_r_hit;
    logic                w_upd;

    assign w_r_idx = bus.r_pc[IDX_BITS+1:2];
    assign w_r_tag = bus.r_pc[TAG_HI:TAG_LO];
    assign w_r_hit = r_vld[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);
    assign w_upd   = w_active & (bus.r_br | bus.r_jl);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_vld[i] <= 1'b0;
                r_ctr[i] <= 2'b00;
            end
        end else if (w_upd) begin
            if (w_r_hit) begin
                if (w_act_taken) begin
                    r_ctr[w_r_idx] <= (r_ctr[w_r_idx] == 2'b11) ? 2'b11 : r_ctr[w_r_idx] + 2'b01;
                    r_tgt[w_r_idx] <= w_act_target;
                end else begin
                    r_ctr[w_r_idx] <= (r_ctr[w_r_idx] == 2'b00) ? 2'b00 : r_ctr[w_r_idx] - 2'b01;
                end
            end else if (w_act_taken) begin
                r_vld[w_r_idx] <= 1'b1;
                r_tag[w_r_idx] <= w_r_tag;
                r_tgt[w_r_idx] <= w_act_target;
                r_jmp[w_r_idx] <= bus.r_jl;
                r_ctr[w_r_idx] <= 2'b10;
            end
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_active & (bus.r_br | bus.r_jl | bus.r_jlr))
                r_stat_br <= r_stat_br + 32'd1;
            if (bus.redirect)
                r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign bus.stat_branches    = r_stat_br;
    assign bus.stat_mispredicts = r_stat_mis;
`endif
endmodule
